// File: rtl/udp_tx_seq_pkg.sv
// Shared constants and types for the UDP transmit sequencer.
package udp_tx_seq_pkg;

    // Nibble-interface command codes; codes 4..15 are reserved and behave as NOP.
    localparam logic [3:0] CMD_NOP   = 4'd0;
    localparam logic [3:0] CMD_DATA  = 4'd1;
    localparam logic [3:0] CMD_SEND  = 4'd2;
    localparam logic [3:0] CMD_CLEAR = 4'd3;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    // UDP header size added to the payload byte count for tx_udp_length.
    localparam logic [15:0] UDP_HDR_LEN = 16'd8;

    // True for commands that do something (and are therefore dropped while busy).
    function automatic logic is_active_cmd(input logic [3:0] code);
        logic active;
        case (code)
            CMD_DATA, CMD_SEND, CMD_CLEAR: active = 1'b1;
            default:                       active = 1'b0;
        endcase
        return active;
    endfunction

endpackage

// File: rtl/udp_tx_seq_buf.sv
// Payload byte buffer: simple dual-port RAM with registered read, feeding a
// skid register and an output register so the stream runs without bubbles
// and holds its data steady while the consumer stalls.
module udp_tx_seq_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int CW    = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic          i_run,
    input  logic [CW-1:0] i_count,
    input  logic          i_pop,
    output logic          o_valid,
    output logic [7:0]    o_data,
    output logic          o_last
);

    logic [7:0]    r_mem [DEPTH];
    logic [CW-1:0] r_rd_ptr;
    logic [7:0]    r_q_data;
    logic          r_q_valid;
    logic          r_q_last;
    logic [7:0]    r_skid_data;
    logic          r_skid_valid;
    logic          r_skid_last;
    logic [7:0]    r_out_data;
    logic          r_out_valid;
    logic          r_out_last;

    logic [1:0]    w_held;
    logic          w_issue;
    logic          w_issue_last;
    logic          w_out_free;

    // Decide whether to launch a RAM read: only when the word it returns is
    // guaranteed a slot in the output or skid register next cycle.
    always_comb begin
        w_held       = {1'b0, r_out_valid} + {1'b0, r_skid_valid}
                     + {1'b0, r_q_valid} - {1'b0, i_pop};
        w_out_free   = !r_out_valid || i_pop;
        w_issue      = i_run && (r_rd_ptr != i_count) && (w_held < 2'd2);
        w_issue_last = (r_rd_ptr == (i_count - {{(CW-1){1'b0}}, 1'b1}));
    end

    // RAM array write and registered read port.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (w_issue) begin
            r_q_data <= r_mem[r_rd_ptr[AW-1:0]];
        end
    end

    // Read pointer, in-flight flag and the skid/output pipeline; idle clears it.
    always_ff @(posedge clk) begin
        if (rst || !i_run) begin
            r_rd_ptr     <= '0;
            r_q_valid    <= 1'b0;
            r_q_last     <= 1'b0;
            r_skid_data  <= 8'h00;
            r_skid_valid <= 1'b0;
            r_skid_last  <= 1'b0;
            r_out_data   <= 8'h00;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
        end else begin
            if (w_issue) begin
                r_rd_ptr  <= r_rd_ptr + {{(CW-1){1'b0}}, 1'b1};
                r_q_valid <= 1'b1;
                r_q_last  <= w_issue_last;
            end else begin
                r_q_valid <= 1'b0;
            end
            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out_data   <= r_skid_data;
                    r_out_last   <= r_skid_last;
                    r_out_valid  <= 1'b1;
                    r_skid_data  <= r_q_data;
                    r_skid_last  <= r_q_last;
                    r_skid_valid <= r_q_valid;
                end else if (r_q_valid) begin
                    r_out_data  <= r_q_data;
                    r_out_last  <= r_q_last;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (r_q_valid) begin
                r_skid_data  <= r_q_data;
                r_skid_last  <= r_q_last;
                r_skid_valid <= 1'b1;
            end else begin
                r_skid_valid <= r_skid_valid;
            end
        end
    end

    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;
    assign o_last  = r_out_last;

endmodule

// File: rtl/udp_tx_sequencer.sv
// Nibble-command front end for the UDP transmit path: packs nibbles into a
// payload buffer, learns the peer from received headers and sequences one
// header + payload frame per SEND.
module udp_tx_sequencer
    import udp_tx_seq_pkg::*;
#(
    parameter int         PAYLOAD_MAX = 64,
    parameter logic [7:0] IP_TTL      = 8'd64,
    parameter logic [5:0] IP_DSCP     = 6'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [3:0]  cmd_code,
    input  logic [3:0]  cmd_data,
    output logic        cmd_ready,
    input  logic [31:0] local_ip,
    input  logic [15:0] local_port,
    input  logic        rx_udp_hdr_valid,
    input  logic        rx_udp_hdr_ready,
    input  logic [31:0] rx_udp_ip_source_ip,
    input  logic [15:0] rx_udp_source_port,
    input  logic [15:0] rx_udp_dest_port,
    output logic        tx_udp_hdr_valid,
    input  logic        tx_udp_hdr_ready,
    output logic [5:0]  tx_udp_ip_dscp,
    output logic [1:0]  tx_udp_ip_ecn,
    output logic [7:0]  tx_udp_ip_ttl,
    output logic [31:0] tx_udp_ip_source_ip,
    output logic [31:0] tx_udp_ip_dest_ip,
    output logic [15:0] tx_udp_source_port,
    output logic [15:0] tx_udp_dest_port,
    output logic [15:0] tx_udp_length,
    output logic [15:0] tx_udp_checksum,
    output logic [7:0]  tx_udp_payload_axis_tdata,
    output logic        tx_udp_payload_axis_tvalid,
    input  logic        tx_udp_payload_axis_tready,
    output logic        tx_udp_payload_axis_tlast,
    output logic        tx_udp_payload_axis_tuser,
    output logic        peer_valid,
    output logic        busy,
    output logic [7:0]  drop_count
);

    localparam int CW = $clog2(PAYLOAD_MAX + 1);
    localparam int AW = $clog2(PAYLOAD_MAX);
    localparam logic [CW-1:0] CNT_MAX = CW'(PAYLOAD_MAX);

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic          r_nib_pend;
    logic [3:0]    r_nib_low;
    logic          r_peer_valid;
    logic [31:0]   r_peer_ip;
    logic [15:0]   r_peer_port;
    logic [7:0]    r_drop;
    logic          r_hdr_valid;
    logic [31:0]   r_src_ip;
    logic [31:0]   r_dst_ip;
    logic [15:0]   r_src_port;
    logic [15:0]   r_dst_port;
    logic [15:0]   r_length;
    logic [7:0]    r_ttl;
    logic [5:0]    r_dscp;

    state_t        w_state_nxt;
    logic          w_drop;
    logic          w_wr_en;
    logic [7:0]    w_wr_data;
    logic          w_cnt_inc;
    logic          w_nib_set;
    logic          w_nib_clr;
    logic          w_clear;
    logic          w_send_ok;
    logic [CW-1:0] w_send_cnt;
    logic          w_learn;
    logic          w_buf_valid;
    logic [7:0]    w_buf_data;
    logic          w_buf_last;
    logic          w_in_payload;
    logic          w_pop;
    logic          w_frame_done;

    assign w_in_payload = (r_state == ST_PAYLOAD);
    assign w_pop        = w_in_payload && w_buf_valid && tx_udp_payload_axis_tready;
    assign w_frame_done = w_pop && w_buf_last;
    assign w_learn      = rx_udp_hdr_valid && rx_udp_hdr_ready
                       && (rx_udp_dest_port == local_port);

    // Command decode, rejection rules and next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        w_drop      = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_data   = 8'h00;
        w_cnt_inc   = 1'b0;
        w_nib_set   = 1'b0;
        w_nib_clr   = 1'b0;
        w_clear     = 1'b0;
        w_send_ok   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_code)
                        CMD_DATA: begin
                            if (r_count == CNT_MAX) begin
                                w_drop = 1'b1;
                            end else if (!r_nib_pend) begin
                                w_nib_set = 1'b1;
                            end else begin
                                w_wr_en   = 1'b1;
                                w_wr_data = {cmd_data, r_nib_low};
                                w_cnt_inc = 1'b1;
                                w_nib_clr = 1'b1;
                            end
                        end
                        CMD_SEND: begin
                            if (!r_peer_valid) begin
                                w_drop = 1'b1;
                            end else if (r_nib_pend) begin
                                if (r_count == CNT_MAX) begin
                                    w_drop = 1'b1;
                                end else begin
                                    w_wr_en   = 1'b1;
                                    w_wr_data = {4'h0, r_nib_low};
                                    w_cnt_inc = 1'b1;
                                    w_nib_clr = 1'b1;
                                    w_send_ok = 1'b1;
                                end
                            end else if (r_count == {CW{1'b0}}) begin
                                w_drop = 1'b1;
                            end else begin
                                w_send_ok = 1'b1;
                            end
                        end
                        CMD_CLEAR: w_clear = 1'b1;
                        default:   w_clear = 1'b0;
                    endcase
                end else begin
                    w_drop = 1'b0;
                end
                if (w_send_ok) begin
                    w_state_nxt = ST_HDR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HDR: begin
                w_drop = cmd_valid && is_active_cmd(cmd_code);
                if (r_hdr_valid && tx_udp_hdr_ready) begin
                    w_state_nxt = ST_PAYLOAD;
                end else begin
                    w_state_nxt = ST_HDR;
                end
            end
            ST_PAYLOAD: begin
                w_drop = cmd_valid && is_active_cmd(cmd_code);
                if (w_frame_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_PAYLOAD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_send_cnt = r_count + {{(CW-1){1'b0}}, w_cnt_inc};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Packer, peer latch, drop counter and header snapshot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= '0;
            r_nib_pend   <= 1'b0;
            r_nib_low    <= 4'h0;
            r_peer_valid <= 1'b0;
            r_peer_ip    <= 32'h0;
            r_peer_port  <= 16'h0;
            r_drop       <= 8'h00;
            r_hdr_valid  <= 1'b0;
            r_src_ip     <= 32'h0;
            r_dst_ip     <= 32'h0;
            r_src_port   <= 16'h0;
            r_dst_port   <= 16'h0;
            r_length     <= 16'h0;
            r_ttl        <= 8'h00;
            r_dscp       <= 6'h00;
        end else begin
            if (w_clear || w_frame_done) begin
                r_count <= '0;
            end else if (w_cnt_inc) begin
                r_count <= w_send_cnt;
            end
            if (w_clear || w_frame_done || w_nib_clr) begin
                r_nib_pend <= 1'b0;
            end else if (w_nib_set) begin
                r_nib_pend <= 1'b1;
                r_nib_low  <= cmd_data;
            end
            if (w_learn) begin
                r_peer_valid <= 1'b1;
                r_peer_ip    <= rx_udp_ip_source_ip;
                r_peer_port  <= rx_udp_source_port;
            end
            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
            if (w_send_ok) begin
                r_hdr_valid <= 1'b1;
                r_src_ip    <= local_ip;
                r_dst_ip    <= r_peer_ip;
                r_src_port  <= local_port;
                r_dst_port  <= r_peer_port;
                r_length    <= UDP_HDR_LEN + 16'(w_send_cnt);
                r_ttl       <= IP_TTL;
                r_dscp      <= IP_DSCP;
            end else if (r_hdr_valid && tx_udp_hdr_ready) begin
                r_hdr_valid <= 1'b0;
            end
        end
    end

    udp_tx_seq_buf #(
        .DEPTH (PAYLOAD_MAX),
        .AW    (AW),
        .CW    (CW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_count[AW-1:0]),
        .i_wr_data (w_wr_data),
        .i_run     (r_state != ST_IDLE),
        .i_count   (r_count),
        .i_pop     (w_pop),
        .o_valid   (w_buf_valid),
        .o_data    (w_buf_data),
        .o_last    (w_buf_last)
    );

    assign cmd_ready                  = (r_state == ST_IDLE);
    assign busy                       = (r_state != ST_IDLE);
    assign peer_valid                 = r_peer_valid;
    assign drop_count                 = r_drop;
    assign tx_udp_hdr_valid           = r_hdr_valid;
    assign tx_udp_ip_dscp             = r_dscp;
    assign tx_udp_ip_ecn              = 2'b00;
    assign tx_udp_ip_ttl              = r_ttl;
    assign tx_udp_ip_source_ip        = r_src_ip;
    assign tx_udp_ip_dest_ip          = r_dst_ip;
    assign tx_udp_source_port         = r_src_port;
    assign tx_udp_dest_port           = r_dst_port;
    assign tx_udp_length              = r_length;
    assign tx_udp_checksum            = 16'h0000;
    assign tx_udp_payload_axis_tdata  = w_buf_data;
    assign tx_udp_payload_axis_tvalid = w_in_payload && w_buf_valid;
    assign tx_udp_payload_axis_tlast  = w_in_payload && w_buf_valid && w_buf_last;
    assign tx_udp_payload_axis_tuser  = 1'b0;

endmodule
